// File: rtl/aac_bs_pkg.sv
// Shared constants and types for the AAC bitstream reader.
//   MAX_BITS : largest field width served per request
//   ACC_W    : width of the bit accumulator
//   state_t  : request-handling FSM states
package aac_bs_pkg;
  localparam int MAX_BITS = 16;
  localparam int ACC_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    ERR  = 2'd2
  } state_t;
endpackage

// File: rtl/aac_byte_fifo.sv
// Synchronous byte FIFO between the stream input and the bit accumulator.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   push, din      : write request and byte (ignored while full)
//   pop, dout      : read request (ignored while empty), head byte (show-ahead)
//   full, empty    : occupancy flags
module aac_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/aac_bitstream_reader.sv
// AAC bitstream reader: buffers stream bytes and serves MSB-first bit fields.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid, in_data, in_ready: byte stream input (valid/ready)
//   rd_req, rd_len, rd_align   : field request (held until rd_ack / err)
//   rd_ack, rd_data            : one-cycle served pulse, right-aligned field
//   err                        : one-cycle pulse for an illegal rd_len
//   bits_avail                 : valid bits in the accumulator
//
// state | meaning
// IDLE  | waiting for a request, or stalled until enough bits are buffered
// ACK   | field served, rd_ack high for this cycle
// ERR   | illegal width requested, err high for this cycle
module aac_bitstream_reader
  import aac_bs_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        rd_req,
  input  logic [4:0]  rd_len,
  input  logic        rd_align,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  output logic        err,
  output logic [5:0]  bits_avail
);
  localparam logic [4:0] MAX_LEN = 5'(MAX_BITS);
  localparam logic [5:0] ACC_BITS = 6'(ACC_W);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, acc_sh, field, ins;
  logic [5:0]       avail_nx, avail_sh, consume, ins_sh;
  logic [15:0]      data_nx;
  logic             len_legal;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_dout;

  aac_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign rd_ack    = (state == ACK);
  assign err       = (state == ERR);
  assign len_legal = (rd_len != 5'd0) && (rd_len <= MAX_LEN);
  assign field     = acc >> (ACC_BITS - {1'b0, rd_len});
  // Refill decision uses the pre-consume count so at most one byte lands per cycle.
  assign fifo_pop  = !fifo_empty && (bits_avail <= 6'd24);

  always_comb begin
    state_nx = state;
    consume  = 6'd0;
    data_nx  = rd_data;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          if (rd_align) begin
            // Only whole bytes are loaded, so the residue mod 8 is the distance to the boundary.
            consume  = {3'b000, bits_avail[2:0]};
            data_nx  = 16'h0000;
            state_nx = ACK;
          end else if (!len_legal) begin
            state_nx = ERR;
          end else if (bits_avail >= {1'b0, rd_len}) begin
            consume  = {1'b0, rd_len};
            data_nx  = field[15:0];
            state_nx = ACK;
          end
        end
      end
      ACK:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Shift out consumed bits first, then insert the refill byte just below the valid region.
    acc_sh   = acc << consume;
    avail_sh = bits_avail - consume;
    ins_sh   = 6'd24 - avail_sh;
    ins      = {24'h000000, fifo_dout} << ins_sh;
    acc_nx   = acc_sh;
    avail_nx = avail_sh;
    if (fifo_pop) begin
      acc_nx   = acc_sh | ins;
      avail_nx = avail_sh + 6'd8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      bits_avail <= 6'd0;
      rd_data    <= 16'h0000;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      bits_avail <= avail_nx;
      rd_data    <= data_nx;
    end
  end
endmodule
